// File: rtl/down_timer.sv
// Loadable down-counter with a two-state control FSM: counts a loaded value to
// zero, pulses Done for one cycle, then stops or reloads from the captured value.
module down_timer #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Load,
  input  logic [WIDTH-1:0] D,
  input  logic             Enable,
  input  logic             Reload,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             terminal_c;

  // The 1->0 step is the terminal edge, so Q never wraps below zero.
  assign terminal_c = (q_q == WIDTH'(1));

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= IDLE;
      q_q     <= '0;
      r_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: Load beats counting; Done only ever comes from a terminal edge.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    r_d     = r_q;
    done_d  = 1'b0;

    if (Load) begin
      q_d     = D;
      r_d     = D;
      state_d = (D != '0) ? RUN : IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          q_d = q_q;
        end
        RUN: begin
          if (Enable) begin
            if (terminal_c) begin
              done_d = 1'b1;
              if (Reload) begin
                q_d = r_q;
              end else begin
                q_d     = '0;
                state_d = IDLE;
              end
            end else begin
              q_d = q_q - WIDTH'(1);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d == RUN);
  end

  assign Q    = q_q;
  assign Busy = busy_q;
  assign Done = done_q;

endmodule

// File: tb/tb_down_timer.sv
// Directed bench for down_timer (WIDTH=3) with hand-computed expected values.
module tb_down_timer;

  localparam int unsigned WIDTH = 3;

  logic             clk;
  logic             rst_n;
  logic             load;
  logic [WIDTH-1:0] d;
  logic             enable;
  logic             reload;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic             done;

  int n_cmp;
  int n_err;

  down_timer #(.WIDTH(WIDTH)) dut (
    .Clock  (clk),
    .Resetn (rst_n),
    .Load   (load),
    .D      (d),
    .Enable (enable),
    .Reload (reload),
    .Q      (q),
    .Busy   (busy),
    .Done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one edge and sample just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input int eq, input int eb, input int ed);
    check({tag, ".Q"},    32'(q),    32'(eq));
    check({tag, ".Busy"}, 32'(busy), 32'(eb));
    check({tag, ".Done"}, 32'(done), 32'(ed));
  endtask

  task automatic do_load(input int val);
    load = 1'b1;
    d    = WIDTH'(val);
    step();
    load = 1'b0;
  endtask

  int exp_q [];
  int exp_d [];

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst_n  = 1'b0;
    load   = 1'b0;
    d      = '0;
    enable = 1'b0;
    reload = 1'b0;

    #3;
    expect_out("reset", 0, 0, 0);
    #10;
    rst_n = 1'b1;
    step();

    // Idle inertness
    enable = 1'b1;
    reload = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out("idle", 0, 0, 0);
    end

    // One-shot count from 5
    reload = 1'b0;
    do_load(5);
    expect_out("oneshot.load", 5, 1, 0);
    for (int v = 4; v >= 1; v--) begin
      step();
      expect_out("oneshot.cnt", v, 1, 0);
    end
    step();
    expect_out("oneshot.term", 0, 0, 1);
    step();
    expect_out("oneshot.after", 0, 0, 0);
    step();
    expect_out("oneshot.after2", 0, 0, 0);

    // Auto-reload from 3
    reload = 1'b1;
    do_load(3);
    expect_out("auto3.load", 3, 1, 0);
    exp_q = '{2, 1, 3, 2, 1, 3, 2};
    exp_d = '{0, 0, 1, 0, 0, 1, 0};
    foreach (exp_q[i]) begin
      step();
      expect_out("auto3.cnt", exp_q[i], 1, exp_d[i]);
    end

    // Auto-reload from 1: Done every cycle
    do_load(1);
    expect_out("auto1.load", 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_out("auto1.cnt", 1, 1, 1);
    end

    // Pause with max load value
    reload = 1'b0;
    do_load(7);
    expect_out("pause.load", 7, 1, 0);
    step();
    expect_out("pause.en1", 6, 1, 0);
    enable = 1'b0;
    step();
    expect_out("pause.en0a", 6, 1, 0);
    step();
    expect_out("pause.en0b", 6, 1, 0);
    enable = 1'b1;
    step();
    expect_out("pause.en1b", 5, 1, 0);

    // Load collides with the terminal edge
    for (int v = 4; v >= 1; v--) begin
      step();
      expect_out("coll.cnt", v, 1, 0);
    end
    do_load(4);
    expect_out("coll.load4", 4, 1, 0);
    step();
    expect_out("coll.cnt3", 3, 1, 0);
    do_load(0);
    expect_out("coll.load0", 0, 0, 0);
    step();
    expect_out("coll.idle", 0, 0, 0);

    // Enable drops on what would be the terminal edge
    do_load(2);
    expect_out("endrop.load", 2, 1, 0);
    step();
    expect_out("endrop.q1", 1, 1, 0);
    enable = 1'b0;
    step();
    expect_out("endrop.hold", 1, 1, 0);
    enable = 1'b1;
    step();
    expect_out("endrop.term", 0, 0, 1);

    // Reload only matters at the terminal edge
    reload = 1'b1;
    do_load(2);
    reload = 1'b0;
    expect_out("rlmid.load", 2, 1, 0);
    step();
    expect_out("rlmid.q1", 1, 1, 0);
    step();
    expect_out("rlmid.term", 0, 0, 1);

    // Asynchronous reset mid-count
    do_load(5);
    expect_out("arst.load", 5, 1, 0);
    step();
    step();
    expect_out("arst.q3", 3, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("arst.async", 0, 0, 0);
    step();
    expect_out("arst.held", 0, 0, 0);
    #2;
    rst_n = 1'b1;
    reload = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("arst.post", 0, 0, 0);
    end
    do_load(2);
    expect_out("arst.reload", 2, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
